// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan : time-multiplexed 7-segment display driver.
//   Scans DIGITS packed BCD/hex nibbles onto one shared active-low segment bus
//   with one active-low anode per digit. Each digit owns DIV clock cycles; the
//   first BLANK_CYC cycles of every slot keep all anodes off to avoid ghosting.
//   The digit word is captured into a shadow register at frame end so that a
//   mid-frame change of i_bcd never tears the displayed value.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_en     scan enable; low blanks the display and parks the scan at digit 0
//   i_bcd    packed digits, digit k = i_bcd[4k+3:4k], digit 0 least significant
//   o_seg    segments, active-low, bit0=a .. bit6=g (registered)
//   o_an     anode enables, active-low, at most one low (registered)
//   o_frame  one-cycle pulse after the last cycle of a full scan frame (registered)
//
// Configuration macro
//   SEG_LZ_SUPPRESS_EN : when defined, digits k>0 whose shadow digits k..DIGITS-1
//                        are all zero stay dark for their whole slot.
// ---------------------------------------------------------------------------
module seg_scan #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned DIV       = 1000,
   parameter int unsigned BLANK_CYC = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [4*DIGITS-1:0]   i_bcd,
   output logic [6:0]            o_seg,
   output logic [DIGITS-1:0]     o_an,
   output logic                  o_frame
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned BCD_W = 4 * DIGITS;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BCD_W-1:0]  shadow_q, shadow_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              frame_q, frame_d;

   logic              slot_last;
   logic              frame_end;
   logic [3:0]        digit;
   logic              lz_blank;

   // Active-low gfedcba pattern for one hex nibble.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b1000000;
         4'h1:    pat = 7'b1111001;
         4'h2:    pat = 7'b0100100;
         4'h3:    pat = 7'b0110000;
         4'h4:    pat = 7'b0011001;
         4'h5:    pat = 7'b0010010;
         4'h6:    pat = 7'b0000010;
         4'h7:    pat = 7'b1111000;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0010000;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b0000011;
         4'hC:    pat = 7'b1000110;
         4'hD:    pat = 7'b0100001;
         4'hE:    pat = 7'b0000110;
         default: pat = 7'b0001110;
      endcase
      return pat;
   endfunction

   // Slot/frame boundary flags, current digit select and leading-zero test.
   always_comb begin
      slot_last = (cnt_q == CNT_LAST);
      frame_end = slot_last && (idx_q == IDX_LAST);
      digit     = 4'h0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) digit = shadow_q[4*k +: 4];
      end
`ifdef SEG_LZ_SUPPRESS_EN
      // Dark when this digit and every more significant digit are zero.
      lz_blank = (idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == '0);
`else
      lz_blank = 1'b0;
`endif
   end

   // State registers and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         seg_q    <= 7'h7F;
         an_q     <= '1;
         frame_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         frame_q  <= frame_d;
      end
   end

   // Next-state: scan position and shadow capture.
   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      if (!i_en) begin
         // Parked: restart from digit 0 with a fresh copy of the input.
         cnt_d    = '0;
         idx_d    = '0;
         shadow_d = i_bcd;
      end else begin
         cnt_d = slot_last ? '0 : cnt_q + CNT_W'(1);
         if (slot_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         if (frame_end) shadow_d = i_bcd;
      end
   end

   // Output decode for the current (idx, cnt); registered above.
   always_comb begin
      seg_d   = 7'h7F;
      an_d    = '1;
      frame_d = 1'b0;
      if (i_en) begin
         frame_d = frame_end;
         if ((cnt_q >= BLANK_END) && !lz_blank) begin
            an_d[idx_q] = 1'b0;
            seg_d       = decode(digit);
         end
      end
   end

   assign o_seg   = seg_q;
   assign o_an    = an_q;
   assign o_frame = frame_q;

endmodule
